// File: rtl/conv_weight_streamer_pkg.sv
// Shared conv parameters: conv_3x3 defaults, weight-set sizing helpers and
// the weight-streamer FSM encoding.
package conv_weight_streamer_pkg;

    localparam int CONV_DATA_WIDTH      = 32;
    localparam int CONV_KERNEL          = 3;
    localparam int CONV_CHANNEL_NUM_IN  = 256;
    localparam int CONV_CHANNEL_NUM_OUT = 256;
    localparam int CONV_ADDR_WIDTH      = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Words in one output-channel kernel set.
    function automatic int set_size(input int kernel, input int ch_in);
        return kernel * kernel * ch_in;
    endfunction

    // Smallest weight-memory address width that covers every set.
    function automatic int min_addr_width(input int kernel, input int ch_in, input int ch_out);
        return $clog2(set_size(kernel, ch_in) * ch_out);
    endfunction

endpackage

// File: rtl/conv_weight_streamer.sv
// Streams kernel sets from weight memory to the conv engine: the first set on
// start, each later set on a consumer weight_req.
module conv_weight_streamer
    import conv_weight_streamer_pkg::*;
#(
    parameter int DATA_WIDTH      = CONV_DATA_WIDTH,
    parameter int CHANNEL_NUM_IN  = CONV_CHANNEL_NUM_IN,
    parameter int CHANNEL_NUM_OUT = CONV_CHANNEL_NUM_OUT,
    parameter int KERNEL          = CONV_KERNEL,
    parameter int ADDR_WIDTH      = CONV_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  weight_req,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  valid_weight_out,
    output logic                  busy,
    output logic                  done
);

    localparam int SET_SIZE = set_size(KERNEL, CHANNEL_NUM_IN);
    localparam int WORD_W   = $clog2(SET_SIZE + 1);
    localparam int SET_W    = $clog2(CHANNEL_NUM_OUT + 1);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(SET_SIZE - 1);
    localparam logic [SET_W-1:0]  LAST_SET  = SET_W'(CHANNEL_NUM_OUT - 1);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] word_idx;
    logic [SET_W-1:0]  set_idx;
    logic              pending;
    logic              rd_en_q;
    logic              last_word;

    assign last_word = (word_idx == LAST_WORD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next = state;
        mem_rd_en  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                mem_rd_en = 1'b1;
                if (last_word) state_next = (set_idx == LAST_SET) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (pending || weight_req) state_next = ST_LOAD;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Addresses are contiguous across sets, so a single running address
    // tracks set_idx*SET_SIZE + word_idx without a multiplier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx <= '0;
            set_idx  <= '0;
            mem_addr <= '0;
        end else if (state == ST_LOAD) begin
            if (last_word) begin
                word_idx <= '0;
                if (set_idx == LAST_SET) begin
                    set_idx  <= '0;
                    mem_addr <= '0;
                end else begin
                    set_idx  <= set_idx + SET_W'(1);
                    mem_addr <= mem_addr + ADDR_WIDTH'(1);
                end
            end else begin
                word_idx <= word_idx + WORD_W'(1);
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // One-deep request memory; a request still pending at the end of the
    // download is discarded so it cannot leak into the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else if ((state == ST_WAIT && state_next == ST_LOAD) || state == ST_DONE) begin
            pending <= 1'b0;
        end else if (state == ST_LOAD && weight_req) begin
            pending <= 1'b1;
        end
    end

    // Read data returns the cycle after the strobe; the strobe is delayed
    // alongside it so valid_weight_out lines up with the registered word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en_q          <= 1'b0;
            valid_weight_out <= 1'b0;
            weight_out       <= '0;
        end else begin
            rd_en_q          <= mem_rd_en;
            valid_weight_out <= rd_en_q;
            if (rd_en_q) weight_out <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_conv_weight_streamer.sv
// Directed bench for conv_weight_streamer with KERNEL=3, CHANNEL_NUM_IN=2,
// CHANNEL_NUM_OUT=2 and a weight memory whose word equals its address.
module tb_conv_weight_streamer;
    import conv_weight_streamer_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int SET   = 18;
    localparam int TOTAL = 36;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          weight_req = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] weight_out;
    logic          valid_weight_out;
    logic          busy;
    logic          done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int t_start = 0;
    int addr_q[$];
    int addr_cyc_q[$];
    int out_q[$];
    int out_cyc_q[$];

    conv_weight_streamer #(
        .DATA_WIDTH(DW), .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .KERNEL(3), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .weight_req(weight_req),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .weight_out(weight_out), .valid_weight_out(valid_weight_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= DW'(mem_addr);

    always @(negedge clk) begin
        if (mem_rd_en) begin
            addr_q.push_back(int'(mem_addr));
            addr_cyc_q.push_back(cyc);
        end
        if (valid_weight_out) begin
            out_q.push_back(int'(weight_out));
            out_cyc_q.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    // Index of the first entry that breaks base+(i%modv) or within-set
    // contiguity; -2 for a wrong length, -1 when the log is as required.
    function automatic int first_bad(input int q[$], input int cq[$], input int n,
                                     input int base, input int modv);
        if (q.size() != n || cq.size() != n) return -2;
        for (int i = 0; i < n; i++) begin
            if (q[i] != base + (i % modv)) return i;
            if ((i % SET) != 0 && cq[i] != cq[i-1] + 1) return i;
        end
        return -1;
    endfunction

    task automatic clear_log();
        addr_q.delete();
        addr_cyc_q.delete();
        out_q.delete();
        out_cyc_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start   = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_req();
        @(negedge clk);
        weight_req = 1'b1;
        @(negedge clk);
        weight_req = 1'b0;
    endtask

    task automatic wait_state(input state_t st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut.state == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({mem_rd_en, valid_weight_out, busy, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: rd_en/valid/busy/done=%b required 0000",
                     {mem_rd_en, valid_weight_out, busy, done});
        end
        vectors++;
        if (mem_addr !== '0 || weight_out !== '0) begin
            miscompares++;
            $display("FAIL reset_data: mem_addr=%0d weight_out=%0d required 0/0", mem_addr, weight_out);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_set();
        bit ok;
        int bad;
        int lat;
        clear_log();
        pulse_start();
        wait_state(ST_WAIT, 40, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL set0_reach_wait: state=%0d required WAIT within 40 cycles", dut.state);
        end
        repeat (4) @(negedge clk);
        vectors++;
        bad = first_bad(addr_q, addr_cyc_q, SET, 0, TOTAL);
        if (bad != -1) begin
            miscompares++;
            $display("FAIL set0_addr: size=%0d bad_idx=%0d required %0d contiguous addresses from 0",
                     addr_q.size(), bad, SET);
        end
        vectors++;
        bad = first_bad(out_q, out_cyc_q, SET, 0, TOTAL);
        if (bad != -1) begin
            miscompares++;
            $display("FAIL set0_data: size=%0d bad_idx=%0d required %0d contiguous words from 0",
                     out_q.size(), bad, SET);
        end
        vectors++;
        lat = (addr_cyc_q.size() > 0) ? addr_cyc_q[0] - t_start : -1;
        if (lat != 1) begin
            miscompares++;
            $display("FAIL first_rd_en_latency: got %0d cycles required 1", lat);
        end
        vectors++;
        lat = (out_cyc_q.size() > 0) ? out_cyc_q[0] - t_start : -1;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL first_valid_latency: got %0d cycles required 3", lat);
        end
        vectors++;
        if (dut.state !== ST_WAIT || busy !== 1'b1 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL set0_wait: state=%0d busy=%b done_cnt=%0d required WAIT/1/0",
                     dut.state, busy, done_cnt);
        end
        vectors++;
        if (weight_out !== DW'(17) || valid_weight_out !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_last: weight_out=%0d valid=%b required 17/0", weight_out, valid_weight_out);
        end
    endtask

    task automatic test_second_set();
        bit ok;
        int bad;
        clear_log();
        pulse_req();
        wait_done(40, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL set1_done: done not seen, required within 40 cycles");
        end
        repeat (3) @(negedge clk);
        vectors++;
        bad = first_bad(addr_q, addr_cyc_q, SET, SET, TOTAL);
        if (bad != -1) begin
            miscompares++;
            $display("FAIL set1_addr: size=%0d bad_idx=%0d required %0d contiguous addresses from 18",
                     addr_q.size(), bad, SET);
        end
        vectors++;
        bad = first_bad(out_q, out_cyc_q, SET, SET, TOTAL);
        if (bad != -1) begin
            miscompares++;
            $display("FAIL set1_data: size=%0d bad_idx=%0d required %0d contiguous words from 18",
                     out_q.size(), bad, SET);
        end
        vectors++;
        if (done_cnt != 1 || busy !== 1'b0 || dut.state !== ST_IDLE || mem_addr !== '0) begin
            miscompares++;
            $display("FAIL set1_end: done_cnt=%0d busy=%b state=%0d mem_addr=%0d required 1/0/IDLE/0",
                     done_cnt, busy, dut.state, mem_addr);
        end
    endtask

    task automatic test_pending_req();
        bit ok;
        int bad;
        int gap;
        clear_log();
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_req();
        repeat (2) @(negedge clk);
        pulse_req();
        wait_done(80, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL pending_done: done not seen, required within 80 cycles");
        end
        repeat (3) @(negedge clk);
        vectors++;
        bad = first_bad(addr_q, addr_cyc_q, TOTAL, 0, TOTAL);
        if (bad != -1) begin
            miscompares++;
            $display("FAIL pending_addr: size=%0d bad_idx=%0d required %0d addresses 0..35",
                     addr_q.size(), bad, TOTAL);
        end
        vectors++;
        bad = first_bad(out_q, out_cyc_q, TOTAL, 0, TOTAL);
        if (bad != -1) begin
            miscompares++;
            $display("FAIL pending_data: size=%0d bad_idx=%0d required %0d words 0..35",
                     out_q.size(), bad, TOTAL);
        end
        vectors++;
        gap = (addr_cyc_q.size() > SET) ? addr_cyc_q[SET] - addr_cyc_q[SET-1] : -1;
        if (gap != 2) begin
            miscompares++;
            $display("FAIL pending_gap: set boundary gap=%0d cycles required 2", gap);
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL pending_done_cnt: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_ignored_inputs();
        bit ok;
        int bad;
        clear_log();
        pulse_req();
        repeat (2) @(negedge clk);
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_state(ST_WAIT, 40, ok);
        repeat (4) @(negedge clk);
        vectors++;
        if (!ok || dut.state !== ST_WAIT) begin
            miscompares++;
            $display("FAIL idle_req_ignored: reached_wait=%b state=%0d required 1/WAIT", ok, dut.state);
        end
        pulse_req();
        wait_done(40, ok);
        repeat (3) @(negedge clk);
        vectors++;
        bad = first_bad(addr_q, addr_cyc_q, TOTAL, 0, TOTAL);
        if (bad != -1) begin
            miscompares++;
            $display("FAIL ignored_addr: size=%0d bad_idx=%0d required %0d addresses 0..35",
                     addr_q.size(), bad, TOTAL);
        end
        vectors++;
        bad = first_bad(out_q, out_cyc_q, TOTAL, 0, TOTAL);
        if (bad != -1 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL ignored_data: size=%0d bad_idx=%0d done_cnt=%0d required %0d words, 1 done",
                     out_q.size(), bad, done_cnt, TOTAL);
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        bit found;
        int bad;
        clear_log();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_rd_en && mem_addr == AW'(7)) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL mid_reach_word7: address 7 not read, required within 30 cycles");
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({mem_rd_en, valid_weight_out, busy, done} !== 4'b0000 || mem_addr !== '0 || weight_out !== '0) begin
            miscompares++;
            $display("FAIL mid_async_reset: rd_en/valid/busy/done=%b addr=%0d weight=%0d required all 0",
                     {mem_rd_en, valid_weight_out, busy, done}, mem_addr, weight_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_log();
        repeat (6) @(negedge clk);
        vectors++;
        if (out_q.size() != 0 || addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_no_activity: valid words=%0d reads=%0d required 0/0", out_q.size(), addr_q.size());
        end
        pulse_start();
        wait_state(ST_WAIT, 40, ok);
        repeat (4) @(negedge clk);
        vectors++;
        bad = first_bad(out_q, out_cyc_q, SET, 0, TOTAL);
        if (!ok || bad != -1) begin
            miscompares++;
            $display("FAIL mid_restart: reached_wait=%b size=%0d bad_idx=%0d required words 0..17",
                     ok, out_q.size(), bad);
        end
        pulse_req();
        wait_done(40, ok);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok1;
        bit ok2;
        int bad;
        int t2;
        int lat;
        clear_log();
        pulse_start();
        wait_state(ST_WAIT, 40, ok1);
        pulse_req();
        wait_done(40, ok1);
        pulse_start();
        t2 = t_start;
        wait_state(ST_WAIT, 40, ok2);
        pulse_req();
        wait_done(40, ok2);
        repeat (3) @(negedge clk);
        vectors++;
        if (!ok1 || !ok2 || done_cnt != 2) begin
            miscompares++;
            $display("FAIL b2b_done: run1=%b run2=%b done_cnt=%0d required 1/1/2", ok1, ok2, done_cnt);
        end
        vectors++;
        bad = first_bad(addr_q, addr_cyc_q, 2 * TOTAL, 0, TOTAL);
        if (bad != -1) begin
            miscompares++;
            $display("FAIL b2b_addr: size=%0d bad_idx=%0d required 72 reads, 0..35 twice",
                     addr_q.size(), bad);
        end
        vectors++;
        bad = first_bad(out_q, out_cyc_q, 2 * TOTAL, 0, TOTAL);
        if (bad != -1) begin
            miscompares++;
            $display("FAIL b2b_data: size=%0d bad_idx=%0d required 72 words, 0..35 twice",
                     out_q.size(), bad);
        end
        vectors++;
        lat = (out_cyc_q.size() > TOTAL) ? out_cyc_q[TOTAL] - t2 : -1;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d cycles required 3", lat);
        end
    endtask

    initial begin
        test_reset();
        test_first_set();
        test_second_set();
        test_pending_req();
        test_ignored_inputs();
        test_reset_mid_load();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
